noise_trigger_sequencer: RTL and testbench
==========================================

// Module: noise_trigger_sequencer
// PURPOSE
//  Owns the shell and explosion noise channels behind the CPU sound-control latch.
//  Turns CPU write edges into timed one-shot enable pulses and latches loud/soft per shot.
//  Arbitrates the two channels when exclusive mode is set.
//  Drives sound_enable, shell_en/ls and explo_en/ls into the noise source / noise_sound path.
// PARAMETERS
//  SHELL_HOLD   24    12 kHz ticks shell_en held high per shot
//  SHELL_DECAY  3072  ticks after hold during which the shell channel counts as busy
//  EXPLO_HOLD   48    ticks explo_en held high per shot
//  EXPLO_DECAY  6144  ticks after hold during which the explosion channel counts as busy
//  EXCLUSIVE    1     1: explosion preempts shell; shell is blocked while explosion is busy
//  CNT_W        14    one-shot counter width; must hold max(HOLD, DECAY)
// PORTS
//  clk           in   1  system clock
//  reset_n       in   1  asynchronous, active-low reset
//  clk_12KHz_en  in   1  one-cycle tick enable that times all counters
//  cpu_wr        in   1  one-cycle write strobe to the sound-control latch
//  cpu_data      in   8  [0]explo_ls [1]explo_trig [2]shell_ls [3]shell_trig [5]sound_en; others ignored
//  sound_enable  out  1  registered copy of latch bit 5
//  shell_en      out  1  shell noise gate
//  shell_ls      out  1  shell loud/soft, captured at trigger
//  explo_en      out  1  explosion noise gate
//  explo_ls      out  1  explosion loud/soft, captured at trigger
//  shell_busy    out  1  shell channel in HOLD or DECAY
//  explo_busy    out  1  explosion channel in HOLD or DECAY
// BEHAVIOUR
//  Reset: latch=0 and every output=0; both channels IDLE, counters 0. Reset mid-shot aborts the shot immediately.
//  Latch: on a clk edge with cpu_wr=1, latch<=cpu_data; sound_enable follows latch[5] in the same cycle.
//  Trigger: rising edge of a latch trig bit (old 0 -> new 1) is a shot request. Rewriting 1 over 1 is not an edge.
//  Timing: request raised by the write at edge N -> x_en=1 and x_ls=cpu_data[ls] after edge N+1.
//  Per-channel FSM (noise_oneshot), counter advances only on clk_12KHz_en:
//   IDLE  --req--> HOLD, cnt=HOLD-1; x_en=1
//   HOLD  --tick & cnt==0--> DECAY, cnt=DECAY-1; x_en=0; analog decay runs downstream
//   DECAY --tick & cnt==0--> IDLE
//   HOLD/DECAY --req--> HOLD, reload cnt, recapture ls (retrigger)
//  busy = (state != IDLE). x_ls holds its captured value until the next accepted request.
//  Counter reload and terminal checks are exact: HOLD ticks of x_en, then DECAY ticks of busy.
//  Tick arriving on the same cycle as a request: the request wins and the counter reloads.
//  sound_enable=0: both FSMs are forced to IDLE and x_en=0 next cycle, and new requests are dropped.
//   Latched ls values are kept.
//  EXCLUSIVE=1:
//   - explo request while shell is busy: shell forced to IDLE in the same cycle explo enters HOLD.
//   - shell request while explo is busy: dropped; no retroactive start.
//   - simultaneous shell and explo requests: explo accepted, shell dropped.
//  EXCLUSIVE=0: the channels are fully independent.
//  x_en and x_ls are registered (no comb path from cpu_*). Unused data bits are stored but have no effect.
// STRUCTURE
//  noise_ctrl_pkg:
//   - latch bit-position localparams
//   - typedef enum logic[1:0] {OS_IDLE, OS_HOLD, OS_DECAY} os_state_t
//  noise_oneshot sub-module (params HOLD, DECAY, CNT_W; ports req, kill, tick, ls_in -> en, ls, busy):
//   - instantiated twice
//   - top holds the latch, edge detect and arbitration/kill logic
// TESTING
//  1 Reset:
//    - assert reset_n=0 mid-HOLD -> all outputs 0 asynchronously
//    - release -> outputs stay 0 with no writes
//  2 Shell shot:
//    - write 0x20, then 0x2C -> shell_en=1, shell_ls=1 one clk later
//    - shell_en=1 for exactly 24 ticks; shell_busy falls after 24+3072 ticks
//  3 Retrigger:
//    - explo shot, write 0x20, then 0x22 at tick 30 of HOLD -> explo_en stays 1
//    - explo_en ends 48 ticks after the retrigger; explo_ls=0
//  4 Kill: write 0x08 (sound_en=0) while shell is active -> shell_en=0 and busy=0 next clk; later 0x08 writes give no pulse
//  5 Exclusive:
//    - shell busy, write 0x22 -> shell_busy=0 and explo_en=1 same cycle
//    - during explo, write 0x28 -> no shell_en
//  6 Simultaneous:
//    - write 0x2A with EXCLUSIVE=1 -> only explo fires
//    - EXCLUSIVE=0 -> both fire on the same clk; tick coincident with the write still gives full HOLD

Source files
------------

// File: rtl/noise_ctrl_pkg.sv
// noise_ctrl_pkg
//   Shared definitions for the shell/explosion noise trigger sequencer:
//   bit positions inside the CPU sound-control latch, channel indices used
//   by the per-channel generate loop in the top, and the one-shot state type.
//   No ports (package).

package noise_ctrl_pkg;

  // Sound-control latch bit positions
  localparam int LB_EXPLO_LS   = 0;
  localparam int LB_EXPLO_TRIG = 1;
  localparam int LB_SHELL_LS   = 2;
  localparam int LB_SHELL_TRIG = 3;
  localparam int LB_SOUND_EN   = 5;

  // Channel indices into the per-channel packed vectors
  localparam int NUM_CH   = 2;
  localparam int CH_EXPLO = 0;
  localparam int CH_SHELL = 1;

  typedef enum logic [1:0] {
    OS_IDLE  = 2'd0,
    OS_HOLD  = 2'd1,
    OS_DECAY = 2'd2
  } os_state_t;

  // Latch bit that carries a channel's trigger
  function automatic int trig_bit(input int ch);
    return (ch == CH_EXPLO) ? LB_EXPLO_TRIG : LB_SHELL_TRIG;
  endfunction

  // Latch bit that carries a channel's loud/soft select
  function automatic int ls_bit(input int ch);
    return (ch == CH_EXPLO) ? LB_EXPLO_LS : LB_SHELL_LS;
  endfunction

endpackage

// File: rtl/noise_oneshot.sv
// noise_oneshot
//   One noise channel: a request opens the gate for HOLD ticks, then the
//   channel stays busy for DECAY more ticks while the analog decay runs
//   downstream. A request in HOLD or DECAY retriggers (reload + recapture ls).
//   kill forces IDLE and beats a simultaneous request. All outputs registered.
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   req      in   accepted shot request (one cycle)
//   kill     in   force IDLE, gate off
//   tick     in   counter advance enable
//   ls_in    in   loud/soft value captured with req
//   en       out  noise gate
//   ls       out  captured loud/soft
//   busy     out  state != IDLE

module noise_oneshot #(
  parameter int HOLD  = 24,
  parameter int DECAY = 3072,
  parameter int CNT_W = 14
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic kill,
  input  logic tick,
  input  logic ls_in,
  output logic en,
  output logic ls,
  output logic busy
);
  import noise_ctrl_pkg::*;

  // Counters load N-1 and expire on the tick seen at zero: exactly N ticks.
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] DECAY_LD = CNT_W'(DECAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  os_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OS_IDLE;
      cnt   <= '0;
      en    <= 1'b0;
      ls    <= 1'b0;
      busy  <= 1'b0;
    end else if (kill) begin
      // ls deliberately kept: it only changes on an accepted request
      state <= OS_IDLE;
      cnt   <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
    end else if (req) begin
      // Also covers retrigger and a tick landing on the same cycle
      state <= OS_HOLD;
      cnt   <= HOLD_LD;
      en    <= 1'b1;
      ls    <= ls_in;
      busy  <= 1'b1;
    end else if (tick) begin
      unique case (state)
        OS_HOLD: begin
          if (cnt == '0) begin
            state <= OS_DECAY;
            cnt   <= DECAY_LD;
            en    <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        OS_DECAY: begin
          if (cnt == '0) begin
            state <= OS_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noise_trigger_sequencer.sv
// noise_trigger_sequencer
//   Sits behind the CPU sound-control latch. Detects 0->1 edges on the
//   shell/explosion trigger bits, arbitrates the two channels (explosion
//   wins when EXCLUSIVE), and runs one noise_oneshot per channel.
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   clk_12KHz_en  in   one-cycle tick that times all counters
//   cpu_wr        in   write strobe to the sound-control latch
//   cpu_data[7:0] in   [0]explo_ls [1]explo_trig [2]shell_ls [3]shell_trig [5]sound_en
//   sound_enable  out  latch bit 5
//   shell_en/ls   out  shell gate / captured loud-soft
//   explo_en/ls   out  explosion gate / captured loud-soft
//   shell_busy    out  shell channel in HOLD or DECAY
//   explo_busy    out  explosion channel in HOLD or DECAY

module noise_trigger_sequencer #(
  parameter int SHELL_HOLD  = 24,
  parameter int SHELL_DECAY = 3072,
  parameter int EXPLO_HOLD  = 48,
  parameter int EXPLO_DECAY = 6144,
  parameter bit EXCLUSIVE   = 1'b1,
  parameter int CNT_W       = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_12KHz_en,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  output logic       sound_enable,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls,
  output logic       shell_busy,
  output logic       explo_busy
);
  import noise_ctrl_pkg::*;

  localparam logic EXCL = EXCLUSIVE;

  logic [7:0]        latch;
  logic [NUM_CH-1:0] trig_new, trig_old, rise_q, ls_src;
  logic [NUM_CH-1:0] acc, kill, en, ls, busy;
  logic              explo_acc, shell_acc;

  // Stored but never interpreted
  logic unused_bits;
  assign unused_bits = ^{latch[7:6], latch[4]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) latch <= '0;
    else if (cpu_wr) latch <= cpu_data;
  end

  assign sound_enable = latch[LB_SOUND_EN];

  // Edge is judged against the latch contents being overwritten, so a
  // rewrite of 1 over 1 is not a request. The request is registered and
  // reaches the one-shots one cycle after the write, alongside the new
  // latch value that supplies ls and sound_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rise_q <= '0;
    else          rise_q <= {NUM_CH{cpu_wr}} & trig_new & ~trig_old;
  end

  // Arbitration: sound off kills both and drops requests. In exclusive
  // mode explosion preempts shell, and a shell request is dropped while
  // explosion is busy or being accepted in the same cycle.
  assign explo_acc = rise_q[CH_EXPLO] & sound_enable;
  assign shell_acc = rise_q[CH_SHELL] & sound_enable
                   & ~(EXCL & (explo_acc | busy[CH_EXPLO]));

  assign acc[CH_EXPLO]  = explo_acc;
  assign acc[CH_SHELL]  = shell_acc;
  assign kill[CH_EXPLO] = ~sound_enable;
  assign kill[CH_SHELL] = ~sound_enable | (EXCL & explo_acc);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int TB    = trig_bit(g);
    localparam int LB    = ls_bit(g);
    localparam int HOLD  = (g == CH_EXPLO) ? EXPLO_HOLD  : SHELL_HOLD;
    localparam int DECAY = (g == CH_EXPLO) ? EXPLO_DECAY : SHELL_DECAY;

    assign trig_new[g] = cpu_data[TB];
    assign trig_old[g] = latch[TB];
    assign ls_src[g]   = latch[LB];

    noise_oneshot #(
      .HOLD  (HOLD),
      .DECAY (DECAY),
      .CNT_W (CNT_W)
    ) u_os (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (acc[g]),
      .kill    (kill[g]),
      .tick    (clk_12KHz_en),
      .ls_in   (ls_src[g]),
      .en      (en[g]),
      .ls      (ls[g]),
      .busy    (busy[g])
    );
  end

  assign shell_en   = en[CH_SHELL];
  assign shell_ls   = ls[CH_SHELL];
  assign shell_busy = busy[CH_SHELL];
  assign explo_en   = en[CH_EXPLO];
  assign explo_ls   = ls[CH_EXPLO];
  assign explo_busy = busy[CH_EXPLO];

endmodule

// File: tb/tb_noise_trigger_sequencer.sv
// tb_noise_trigger_sequencer
//   Two instances share data/tick: u_a (EXCLUSIVE=1) and u_b (EXCLUSIVE=0,
//   written only through wr_b). Stimulus pushes the expected output vector
//   and the clock edge it must appear on; the monitor pops on every output
//   change and compares value and edge.

module tb_noise_trigger_sequencer;

  logic       clk = 1'b0, reset_n = 1'b0, tick = 1'b0, cpu_wr = 1'b0, wr_b = 1'b0;
  logic [7:0] cpu_data = 8'h00;

  logic snd_a, sh_en_a, sh_ls_a, ex_en_a, ex_ls_a, sh_busy_a, ex_busy_a;
  logic snd_b, sh_en_b, sh_ls_b, ex_en_b, ex_ls_b, sh_busy_b, ex_busy_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct packed {
    logic snd; logic sh_en; logic sh_ls; logic sh_busy;
    logic ex_en; logic ex_ls; logic ex_busy;
  } obs_t;
  typedef struct { obs_t v; int c; } exp_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  obs_t ca, cb, ex_a, ex_b;
  obs_t pa = '0, pb = '0;

  assign ca = {snd_a, sh_en_a, sh_ls_a, sh_busy_a, ex_en_a, ex_ls_a, ex_busy_a};
  assign cb = {snd_b, sh_en_b, sh_ls_b, sh_busy_b, ex_en_b, ex_ls_b, ex_busy_b};

  noise_trigger_sequencer #(.EXCLUSIVE(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .clk_12KHz_en(tick), .cpu_wr(cpu_wr), .cpu_data(cpu_data),
    .sound_enable(snd_a), .shell_en(sh_en_a), .shell_ls(sh_ls_a), .explo_en(ex_en_a),
    .explo_ls(ex_ls_a), .shell_busy(sh_busy_a), .explo_busy(ex_busy_a));

  noise_trigger_sequencer #(.EXCLUSIVE(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .clk_12KHz_en(tick), .cpu_wr(wr_b), .cpu_data(cpu_data),
    .sound_enable(snd_b), .shell_en(sh_en_b), .shell_ls(sh_ls_b), .explo_en(ex_en_b),
    .explo_ls(ex_ls_b), .shell_busy(sh_busy_b), .explo_busy(ex_busy_b));

  // Monitor: one pop per observed output change
  initial forever begin
    @(negedge clk);
    if (ca !== pa) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL sb_a unexpected change got=%b at edge %0d", ca, cyc);
      end else begin
        ea = qa.pop_front();
        if (ca !== ea.v || (ea.c >= 0 && ea.c != cyc)) begin
          bad++;
          $display("FAIL sb_a got=%b@%0d want=%b@%0d", ca, cyc, ea.v, ea.c);
        end
      end
      pa = ca;
    end
    if (cb !== pb) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL sb_b unexpected change got=%b at edge %0d", cb, cyc);
      end else begin
        eb = qb.pop_front();
        if (cb !== eb.v || (eb.c >= 0 && eb.c != cyc)) begin
          bad++;
          $display("FAIL sb_b got=%b@%0d want=%b@%0d", cb, cyc, eb.v, eb.c);
        end
      end
      pb = cb;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // k = how many steps ahead the change must land; k<0 = any edge
  task automatic push_a(input int k);
    exp_t e; e.v = ex_a; e.c = (k < 0) ? -1 : cyc + k; qa.push_back(e);
  endtask
  task automatic push_b(input int k);
    exp_t e; e.v = ex_b; e.c = (k < 0) ? -1 : cyc + k; qb.push_back(e);
  endtask

  task automatic chk(input string nm, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  // One clock: drive at negedge, DUT samples at posedge, return at next negedge
  task automatic step(input logic wa, input logic wb, input logic [7:0] d, input logic tk);
    cpu_wr = wa; wr_b = wb; cpu_data = d; tick = tk;
    @(posedge clk);
    @(negedge clk);
    cpu_wr = 1'b0; wr_b = 1'b0; tick = 1'b0;
  endtask
  task automatic wr(input logic [7:0] d);  step(1'b1, 1'b0, d, 1'b0); endtask
  task automatic wrb(input logic [7:0] d, input logic t); step(1'b0, 1'b1, d, t); endtask
  task automatic ticks(input int n); repeat (n) step(1'b0, 1'b0, 8'h00, 1'b1); endtask
  task automatic idle(input int n);  repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0); endtask

  initial begin
    ex_a = '0; ex_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_a", ca, '0);
    chk("reset_b", cb, '0);
    reset_n = 1'b1;
    idle(2);

    // 1: reset mid-HOLD
    ex_a.snd = 1; push_a(1); wr(8'h20);
    ex_a.sh_en = 1; ex_a.sh_ls = 1; ex_a.sh_busy = 1; push_a(2); wr(8'h2C);
    idle(1); ticks(3);
    #2 reset_n = 1'b0; ex_a = '0; push_a(-1);
    #1 chk("async_reset", ca, '0);
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    idle(4);
    chk("post_reset", ca, '0);

    // 2: shell shot, 24 ticks gate + 3072 ticks busy
    ex_a.snd = 1; push_a(1); wr(8'h20);
    ex_a.sh_en = 1; ex_a.sh_ls = 1; ex_a.sh_busy = 1; push_a(2); wr(8'h2C);
    idle(1);
    ticks(23); ex_a.sh_en = 0; push_a(1); ticks(1);
    ticks(3071); ex_a.sh_busy = 0; push_a(1); ticks(1);
    idle(2);

    // 3: explosion retrigger at tick 30 of HOLD, then shell blocked in DECAY
    ex_a.ex_en = 1; ex_a.ex_ls = 1; ex_a.ex_busy = 1; push_a(2); wr(8'h23);
    idle(1); ticks(30);
    wr(8'h20);
    ex_a.ex_ls = 0; push_a(2); wr(8'h22);
    idle(1);
    ticks(47); ex_a.ex_en = 0; push_a(1); ticks(1);
    ticks(100); wr(8'h28);
    ticks(6043); ex_a.ex_busy = 0; push_a(1); ticks(1);
    idle(3);

    // 4: sound off kills an active shell; triggers while off are dropped
    wr(8'h20);
    ex_a.sh_en = 1; ex_a.sh_ls = 0; ex_a.sh_busy = 1; push_a(2); wr(8'h28);
    idle(1); ticks(5);
    ex_a.snd = 0; push_a(1);
    ex_a.sh_en = 0; ex_a.sh_busy = 0; push_a(2); wr(8'h08);
    idle(1); wr(8'h00); wr(8'h08); idle(1); ticks(30);

    // 5: explosion preempts shell; shell request during explosion dropped
    ex_a.snd = 1; push_a(1); wr(8'h20);
    ex_a.sh_en = 1; ex_a.sh_ls = 1; ex_a.sh_busy = 1; push_a(2); wr(8'h2C);
    idle(1); ticks(3);
    ex_a.sh_en = 0; ex_a.sh_busy = 0; ex_a.ex_en = 1; ex_a.ex_busy = 1; push_a(2); wr(8'h22);
    idle(1); ticks(2); wr(8'h28); idle(1); ticks(4);
    ex_a.snd = 0; push_a(1);
    ex_a.ex_en = 0; ex_a.ex_busy = 0; push_a(2); wr(8'h00);
    idle(2);

    // 6a: simultaneous requests, exclusive: explosion only
    ex_a.snd = 1; push_a(1); wr(8'h20);
    ex_a.ex_en = 1; ex_a.ex_busy = 1; push_a(2); wr(8'h2A);
    idle(1); ticks(5);
    ex_a.snd = 0; push_a(1);
    ex_a.ex_en = 0; ex_a.ex_busy = 0; push_a(2); wr(8'h00);
    idle(2);

    // 6b: independent channels, ticks on the write and load edges
    ex_b.snd = 1; push_b(1); wrb(8'h20, 1'b0);
    ex_b.sh_en = 1; ex_b.sh_busy = 1; ex_b.ex_en = 1; ex_b.ex_busy = 1; push_b(2); wrb(8'h2A, 1'b1);
    ticks(1);
    ticks(23); ex_b.sh_en = 0; push_b(1); ticks(1);
    ticks(23); ex_b.ex_en = 0; push_b(1); ticks(1);
    ex_b.snd = 0; push_b(1);
    ex_b.sh_busy = 0; ex_b.ex_busy = 0; push_b(2); wrb(8'h00, 1'b0);
    idle(3);

    total++;
    if (qa.size() != 0) begin
      bad++;
      $display("FAIL sb_a_drain left=%0d want=0", qa.size());
    end
    total++;
    if (qb.size() != 0) begin
      bad++;
      $display("FAIL sb_b_drain left=%0d want=0", qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
